// File: rtl/spi_regmap_master_if.sv
// Command/response port of the regmap SPI initiator.
//   master modport: command source (drives cmd_valid/cmd_wr/cmd_addr/cmd_wdata)
//   slave  modport: the initiator block (drives cmd_ready/rsp_valid/rsp_rdata/busy)
interface spi_regmap_master_if;
    localparam int unsigned ADDR_W = 20;
    localparam int unsigned DATA_W = 16;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_wr;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    modport master (
        output cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/spi_regmap_master.sv
// SPI initiator for the regmap SPI-to-APB slave.
// Accepts one register read/write per command, sends it as a 48-bit mode-0
// frame (LSB first: addr[19:0], ctrl[31:20], data[47:32]) and returns the
// 16-bit read data captured from MISO during the data phase.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   cmd (slave modport) cmd_valid/cmd_ready/cmd_wr/cmd_addr/cmd_wdata in,
//                       rsp_valid/rsp_rdata/busy out
//   spi_sclk/spi_cs_n/spi_mosi out, spi_miso in
// Wait parameters of 0 behave as 1 cycle.
module spi_regmap_master #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned CS_SETUP  = 2,
    parameter int unsigned CS_HOLD   = 2,
    parameter int unsigned CS_IDLE   = 4,
    parameter logic [11:0] CTRL_BASE = 12'h170
) (
    input  logic                clk,
    input  logic                rst_n,
    spi_regmap_master_if.slave  cmd,
    output logic                spi_sclk,
    output logic                spi_cs_n,
    output logic                spi_mosi,
    input  logic                spi_miso
);

    localparam int unsigned FRAME_W  = 48;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned BIT_W    = 6;
    localparam int unsigned RD_START = 32;
    localparam int unsigned DIV_W    = $clog2(CLK_DIV + 1);
    localparam int unsigned SH_MAX   = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned WAIT_MAX = (SH_MAX > CS_IDLE) ? SH_MAX : CS_IDLE;
    localparam int unsigned WAIT_CW  = $clog2(WAIT_MAX + 1);
    localparam int unsigned WAIT_W   = (WAIT_CW > 0) ? WAIT_CW : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_HOLD  = 3'd3,
        S_GAP   = 3'd4
    } state_e;

    state_e               state_q,     state_d;
    logic [FRAME_W-1:0]   frame_q,     frame_d;
    logic                 wr_q,        wr_d;
    logic [DATA_W-1:0]    rdata_sh_q,  rdata_sh_d;
    logic [BIT_W-1:0]     bit_cnt_q,   bit_cnt_d;
    logic [DIV_W-1:0]     div_cnt_q,   div_cnt_d;
    logic [WAIT_W-1:0]    wait_cnt_q,  wait_cnt_d;
    logic                 sclk_q,      sclk_d;
    logic                 cs_n_q,      cs_n_d;
    logic                 mosi_q,      mosi_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic                 busy_q,      busy_d;
    logic                 cmd_ready_q, cmd_ready_d;

    logic                 div_last_c;
    logic [11:0]          ctrl_c;

    // Current wait count reaches its parameter on this cycle.
    function automatic logic wait_done(input logic [WAIT_W-1:0] cnt, input int unsigned lim);
        return (32'(cnt) + 32'd1) >= lim;
    endfunction

    assign div_last_c = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign ctrl_c     = {CTRL_BASE[11:3], cmd.cmd_wr, CTRL_BASE[1:0]};

    // Next-state and output decode.
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        wr_d        = wr_q;
        rdata_sh_d  = rdata_sh_q;
        bit_cnt_d   = bit_cnt_q;
        div_cnt_d   = div_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        sclk_d      = sclk_q;
        cs_n_d      = cs_n_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (cmd.cmd_valid && cmd_ready_q) begin
                    frame_d    = {(cmd.cmd_wr ? cmd.cmd_wdata : 16'h0000), ctrl_c, cmd.cmd_addr};
                    wr_d       = cmd.cmd_wr;
                    rdata_sh_d = '0;
                    bit_cnt_d  = '0;
                    div_cnt_d  = '0;
                    wait_cnt_d = '0;
                    sclk_d     = 1'b0;
                    cs_n_d     = 1'b0;
                    mosi_d     = cmd.cmd_addr[0];
                    busy_d     = 1'b1;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                if (wait_done(wait_cnt_q, CS_SETUP)) begin
                    div_cnt_d = '0;
                    state_d   = S_SHIFT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_SHIFT: begin
                if (div_last_c) begin
                    div_cnt_d = '0;
                    if (!sclk_q) begin
                        // Rising phase: sample MISO only in the read data phase.
                        sclk_d = 1'b1;
                        if (!wr_q && (bit_cnt_q >= BIT_W'(RD_START))) begin
                            rdata_sh_d = {spi_miso, rdata_sh_q[DATA_W-1:1]};
                        end
                    end else begin
                        // Falling phase: advance to the next bit or finish the frame.
                        sclk_d = 1'b0;
                        if (bit_cnt_q == BIT_W'(FRAME_W - 1)) begin
                            wait_cnt_d = '0;
                            state_d    = S_HOLD;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                            mosi_d    = frame_q[1];
                            frame_d   = frame_q >> 1;
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            S_HOLD: begin
                if (wait_done(wait_cnt_q, CS_HOLD)) begin
                    cs_n_d      = 1'b1;
                    mosi_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = wr_q ? 16'h0000 : rdata_sh_q;
                    wait_cnt_d  = '0;
                    state_d     = S_GAP;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_GAP: begin
                if (wait_done(wait_cnt_q, CS_IDLE)) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            frame_q     <= '0;
            wr_q        <= 1'b0;
            rdata_sh_q  <= '0;
            bit_cnt_q   <= '0;
            div_cnt_q   <= '0;
            wait_cnt_q  <= '0;
            sclk_q      <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            wr_q        <= wr_d;
            rdata_sh_q  <= rdata_sh_d;
            bit_cnt_q   <= bit_cnt_d;
            div_cnt_q   <= div_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            sclk_q      <= sclk_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd.cmd_ready = cmd_ready_q;
    assign cmd.rsp_valid = rsp_valid_q;
    assign cmd.rsp_rdata = rsp_rdata_q;
    assign cmd.busy      = busy_q;
    assign spi_sclk      = sclk_q;
    assign spi_cs_n      = cs_n_q;
    assign spi_mosi      = mosi_q;

endmodule

// File: tb/tb_spi_regmap_master.sv
// Bench for spi_regmap_master: two instances (CLK_DIV=4 and CLK_DIV=1), an SPI
// slave model per bus that records MOSI frames and serves MISO read data, and
// a reference model built from the frame layout and latency formula.
module tb_spi_regmap_master;

    localparam int unsigned CS_SETUP  = 2;
    localparam int unsigned CS_HOLD   = 2;
    localparam int unsigned CS_IDLE   = 4;
    localparam int unsigned DIV0      = 4;
    localparam int unsigned DIV1      = 1;
    localparam logic [11:0] CTRL_BASE = 12'h170;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        c_wr = 1'b0;
    logic [19:0] c_addr = '0;
    logic [15:0] c_wdata = '0;
    logic [1:0]  vld = 2'b00;

    spi_regmap_master_if if0 ();
    spi_regmap_master_if if1 ();

    assign if0.cmd_valid = vld[0];
    assign if0.cmd_wr    = c_wr;
    assign if0.cmd_addr  = c_addr;
    assign if0.cmd_wdata = c_wdata;
    assign if1.cmd_valid = vld[1];
    assign if1.cmd_wr    = c_wr;
    assign if1.cmd_addr  = c_addr;
    assign if1.cmd_wdata = c_wdata;

    logic sclk0, cs_n0, mosi0, sclk1, cs_n1, mosi1;
    logic miso0 = 1'b0;
    logic miso1 = 1'b0;

    spi_regmap_master #(.CLK_DIV(DIV0), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
                        .CS_IDLE(CS_IDLE), .CTRL_BASE(CTRL_BASE)) dut0 (
        .clk(clk), .rst_n(rst_n), .cmd(if0),
        .spi_sclk(sclk0), .spi_cs_n(cs_n0), .spi_mosi(mosi0), .spi_miso(miso0));

    spi_regmap_master #(.CLK_DIV(DIV1), .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD),
                        .CS_IDLE(CS_IDLE), .CTRL_BASE(CTRL_BASE)) dut1 (
        .clk(clk), .rst_n(rst_n), .cmd(if1),
        .spi_sclk(sclk1), .spi_cs_n(cs_n1), .spi_mosi(mosi1), .spi_miso(miso1));

    // SPI slave model state, one entry per bus.
    logic [15:0] sdata      [2];
    logic [47:0] cap        [2];
    logic [47:0] last_frame [2];
    int          idx        [2];
    int          last_rises [2];
    int          hi_run     [2];
    int          gap_len    [2];
    int          falls      [2];
    int          rsp_cnt    [2];
    int          viol       [2];
    logic        at_rise    [2];
    logic        prev_s     [2] = '{1'b0, 1'b0};
    logic        prev_cs    [2] = '{1'b1, 1'b1};

    int n_cmp = 0;
    int n_mis = 0;

    always @(negedge clk) begin
        logic s, c, m, rv, nb, upd;
        for (int k = 0; k < 2; k++) begin
            s   = (k == 0) ? sclk0 : sclk1;
            c   = (k == 0) ? cs_n0 : cs_n1;
            m   = (k == 0) ? mosi0 : mosi1;
            rv  = (k == 0) ? if0.rsp_valid : if1.rsp_valid;
            upd = 1'b0;
            if (!c && prev_cs[k]) begin
                idx[k]     = 0;
                cap[k]     = '0;
                gap_len[k] = hi_run[k];
                falls[k]   = falls[k] + 1;
                upd        = 1'b1;
            end
            if (!c && s && !prev_s[k]) begin
                if (idx[k] < 48) cap[k][idx[k]] = m;
                at_rise[k] = m;
                idx[k]     = idx[k] + 1;
                upd        = 1'b1;
            end else if (!c && s && (m !== at_rise[k])) begin
                viol[k] = viol[k] + 1;
            end
            if (c && !prev_cs[k]) begin
                last_frame[k] = cap[k];
                last_rises[k] = idx[k];
            end
            hi_run[k] = c ? hi_run[k] + 1 : 0;
            if (rv === 1'b1) rsp_cnt[k] = rsp_cnt[k] + 1;
            if (upd) begin
                nb = (idx[k] >= 32 && idx[k] < 48) ? sdata[k][idx[k] - 32] : 1'($urandom);
                if (k == 0) miso0 = nb;
                else        miso1 = nb;
            end
            prev_s[k]  = s;
            prev_cs[k] = c;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] ref_frame(input logic wr, input logic [19:0] a, input logic [15:0] d);
        logic [63:0] ctrl, f;
        ctrl = 64'((CTRL_BASE & 12'hffb) | (wr ? 12'h004 : 12'h000));
        f    = 64'(a) + (ctrl << 20) + (wr ? (64'(d) << 32) : 64'd0);
        return 48'(f);
    endfunction

    function automatic int exp_lat(input int k);
        return int'(1 + CS_SETUP + 96 * ((k == 0) ? DIV0 : DIV1) + CS_HOLD);
    endfunction

    function automatic logic g_ready(input int k);
        return (k == 0) ? if0.cmd_ready : if1.cmd_ready;
    endfunction
    function automatic logic g_rv(input int k);
        return (k == 0) ? if0.rsp_valid : if1.rsp_valid;
    endfunction
    function automatic logic [15:0] g_rdata(input int k);
        return (k == 0) ? if0.rsp_rdata : if1.rsp_rdata;
    endfunction

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_accept(input int k, output int acyc, output bit ok);
        ok   = 1'b0;
        acyc = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (g_ready(k) === 1'b1) begin
                @(posedge clk);
                #1;
                acyc = cyc;
                ok   = 1'b1;
            end else begin
                step();
            end
        end
        if (!ok) chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_rsp(input int k, output int rcyc, output bit ok);
        ok   = 1'b0;
        rcyc = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            step();
            if (g_rv(k) === 1'b1) begin
                rcyc = cyc;
                ok   = 1'b1;
            end
        end
        if (!ok) chk("rsp_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_ready(input int k);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (g_ready(k) === 1'b1) ok = 1'b1;
            else step();
        end
        if (!ok) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_cmd(input int k, input logic wr, input logic [19:0] a,
                           input logic [15:0] d, input logic [15:0] sd, input string tag);
        int acyc, rcyc, r0;
        bit ok;
        sdata[k] = sd;
        c_wr     = wr;
        c_addr   = a;
        c_wdata  = d;
        r0       = rsp_cnt[k];
        vld[k]   = 1'b1;
        wait_accept(k, acyc, ok);
        step();
        vld[k] = 1'b0;
        if (ok) begin
            wait_rsp(k, rcyc, ok);
            if (ok) begin
                chk({tag, "_latency"}, 64'(rcyc - acyc + 1), 64'(exp_lat(k)));
                chk({tag, "_frame"}, 64'(last_frame[k]), 64'(ref_frame(wr, a, d)));
                chk({tag, "_rises"}, 64'(last_rises[k]), 64'd48);
                repeat (3) step();
                chk({tag, "_pulses"}, 64'(rsp_cnt[k] - r0), 64'd1);
                chk({tag, "_rdata"}, 64'(g_rdata(k)), wr ? 64'd0 : 64'(sd));
            end
        end
        wait_ready(k);
    endtask

    initial begin
        int a1, a2, r1, r0, f0;
        bit ok;
        logic [15:0] sd;
        logic [19:0] a;
        logic [15:0] d;
        logic        w;

        for (int k = 0; k < 2; k++) begin
            sdata[k] = '0;
            cap[k] = '0; last_frame[k] = '0; idx[k] = 0; last_rises[k] = 0;
            hi_run[k] = 0; gap_len[k] = 0; falls[k] = 0; rsp_cnt[k] = 0; viol[k] = 0;
            at_rise[k] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) step();

        // Reset values.
        chk("rst_ready", 64'(if0.cmd_ready), 64'd0);
        chk("rst_rsp_valid", 64'(if0.rsp_valid), 64'd0);
        chk("rst_rdata", 64'(if0.rsp_rdata), 64'd0);
        chk("rst_busy", 64'(if0.busy), 64'd0);
        chk("rst_sclk", 64'(sclk0), 64'd0);
        chk("rst_cs_n", 64'(cs_n0), 64'd1);
        chk("rst_mosi", 64'(mosi0), 64'd0);
        rst_n = 1'b1;
        repeat (2) step();
        chk("idle_ready", 64'(if0.cmd_ready), 64'd1);
        chk("idle_busy", 64'(if0.busy), 64'd0);

        // T1 / T2 directed write and read.
        run_cmd(0, 1'b1, 20'h5ad01, 16'hccdf, 16'($urandom), "t1_wr");
        chk("t1_abs_frame", 64'(last_frame[0]), 64'h0000ccdf1745ad01);
        run_cmd(0, 1'b0, 20'h5ad01, 16'h1234, 16'hccdf, "t2_rd");
        chk("t2_abs_frame", 64'(last_frame[0]), 64'h000000001705ad01);

        // Random commands on the CLK_DIV=4 instance.
        for (int i = 0; i < 5; i++) begin
            run_cmd(0, 1'($urandom), 20'($urandom), 16'($urandom), 16'($urandom), "rnd0");
        end

        // T5: CLK_DIV=1 instance.
        run_cmd(1, 1'b0, 20'h5ad01, 16'h0000, 16'hccdf, "t5_rd");
        for (int i = 0; i < 4; i++) begin
            run_cmd(1, 1'($urandom), 20'($urandom), 16'($urandom), 16'($urandom), "t5_rnd");
        end

        // T3: cmd_valid held high across two commands.
        sd = 16'($urandom);
        sdata[0] = sd;
        c_wr = 1'b0; c_addr = 20'h0abcd; c_wdata = 16'h5555;
        r0 = rsp_cnt[0];
        vld[0] = 1'b1;
        wait_accept(0, a1, ok);
        step();
        c_wr = 1'b1; c_addr = 20'hf0f0f; c_wdata = 16'ha5c3;
        wait_rsp(0, r1, ok);
        chk("t3_frame1", 64'(last_frame[0]), 64'(ref_frame(1'b0, 20'h0abcd, 16'h5555)));
        chk("t3_rdata1", 64'(if0.rsp_rdata), 64'(sd));
        wait_accept(0, a2, ok);
        step();
        vld[0] = 1'b0;
        chk("t3_gap_ge_idle", 64'(gap_len[0] >= int'(CS_IDLE)), 64'd1);
        chk("t3_accept_after_idle", 64'(a2 - r1 >= int'(CS_IDLE)), 64'd1);
        wait_rsp(0, r1, ok);
        chk("t3_frame2", 64'(last_frame[0]), 64'(ref_frame(1'b1, 20'hf0f0f, 16'ha5c3)));
        chk("t3_rdata2", 64'(if0.rsp_rdata), 64'd0);
        repeat (2) step();
        chk("t3_pulses", 64'(rsp_cnt[0] - r0), 64'd2);
        wait_ready(0);

        // T6: inputs disturbed and cmd_valid pulsed while busy.
        sd = 16'($urandom) | 16'h0001;
        sdata[0] = sd;
        a = 20'($urandom); d = 16'($urandom);
        c_wr = 1'b0; c_addr = a; c_wdata = d;
        r0 = rsp_cnt[0];
        f0 = falls[0];
        vld[0] = 1'b1;
        wait_accept(0, a1, ok);
        step();
        vld[0] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            repeat (30) step();
            c_wr = 1'($urandom); c_addr = 20'($urandom); c_wdata = 16'($urandom);
            vld[0] = 1'b1;
            step();
            vld[0] = 1'b0;
        end
        wait_rsp(0, r1, ok);
        chk("t6_frame", 64'(last_frame[0]), 64'(ref_frame(1'b0, a, d)));
        chk("t6_rdata", 64'(if0.rsp_rdata), 64'(sd));
        step();
        vld[0] = 1'b1;
        step();
        vld[0] = 1'b0;
        repeat (30) step();
        chk("t6_no_extra_frame", 64'(falls[0] - f0), 64'd1);
        chk("t6_no_extra_rsp", 64'(rsp_cnt[0] - r0), 64'd1);
        chk("t6_cs_n_idle", 64'(cs_n0), 64'd1);
        chk("t6_busy_idle", 64'(if0.busy), 64'd0);

        // T4: reset in the middle of a read.
        w = 1'b0;
        sdata[0] = 16'($urandom);
        c_wr = 1'b0; c_addr = 20'($urandom); c_wdata = 16'($urandom);
        vld[0] = 1'b1;
        wait_accept(0, a1, ok);
        step();
        vld[0] = 1'b0;
        r0 = rsp_cnt[0];
        for (int i = 0; i < 1000 && !w; i++) begin
            if (idx[0] >= 20) w = 1'b1;
            else step();
        end
        chk("t4_reached_bit20", 64'(w), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t4_cs_n", 64'(cs_n0), 64'd1);
        chk("t4_sclk", 64'(sclk0), 64'd0);
        chk("t4_ready", 64'(if0.cmd_ready), 64'd0);
        repeat (3) step();
        chk("t4_no_rsp", 64'(rsp_cnt[0] - r0), 64'd0);
        chk("t4_rdata_cleared", 64'(if0.rsp_rdata), 64'd0);
        rst_n = 1'b1;
        step();
        chk("t4_ready_after", 64'(if0.cmd_ready), 64'd1);
        run_cmd(0, 1'b0, 20'($urandom), 16'($urandom), 16'($urandom), "t4_next");

        chk("mosi_stable0", 64'(viol[0]), 64'd0);
        chk("mosi_stable1", 64'(viol[1]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
